// File: rtl/player_ctrl.sv
`default_nettype none
// =============================================================================
// Module  : player_ctrl
// Brief   : Player ship motion integrator and handshaked, cooled-down shot issuer.
// Rev     : 1.0  initial release
// =============================================================================
module player_ctrl #(
  parameter int TICK_DIV    = 1666667,
  parameter int X_W         = 10,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 608,
  parameter int X_RESET     = 304,
  parameter int STEP        = 4,
  parameter int SHOT_OFFSET = 14,
  parameter int COOLDOWN    = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           left,
  input  logic           right,
  input  logic           fire,
  input  logic           shot_ack,
  output logic           frame_tick,
  output logic [X_W-1:0] player_x,
  output logic           shot_req,
  output logic [X_W-1:0] shot_x,
  output logic           busy
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(TICK_DIV - 1);
  localparam logic [X_W:0]     c_left_lim  = (X_W+1)'(X_MIN + STEP);
  localparam logic [X_W:0]     c_right_lim = (X_W+1)'(X_MAX);
  localparam logic [X_W:0]     c_step      = (X_W+1)'(STEP);
  localparam logic [X_W-1:0]   c_x_min     = X_W'(X_MIN);
  localparam logic [X_W-1:0]   c_x_max     = X_W'(X_MAX);
  localparam logic [X_W-1:0]   c_x_reset   = X_W'(X_RESET);
  localparam logic [X_W-1:0]   c_offset    = X_W'(SHOT_OFFSET);
  localparam logic [CD_W-1:0]  c_cd_load   = CD_W'(COOLDOWN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_COOL = 2'd2
  } state_t;

  logic           r_left_s1, r_left_s2;
  logic           r_right_s1, r_right_s2;
  logic           r_fire_s1, r_fire_s2, r_fire_prev;
  logic [1:0]     r_sync_vld;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic           r_frame_tick;
  logic [X_W-1:0] r_player_x, w_x_nxt;
  logic [X_W:0]   w_x_ext;
  logic           r_shot_req;
  logic [X_W-1:0] r_shot_x;
  state_t         r_state, w_state_nxt;
  logic [CD_W-1:0] r_cd, w_cd_nxt;
  logic           w_capture;
  logic           w_fire_rise;

  // fire_prev stays high until s2 carries a real sample, so a button held
  // across reset release never looks like a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_left_s1   <= 1'b0;
      r_left_s2   <= 1'b0;
      r_right_s1  <= 1'b0;
      r_right_s2  <= 1'b0;
      r_fire_s1   <= 1'b0;
      r_fire_s2   <= 1'b0;
      r_fire_prev <= 1'b1;
      r_sync_vld  <= 2'b00;
    end else begin
      r_left_s1   <= left;
      r_left_s2   <= r_left_s1;
      r_right_s1  <= right;
      r_right_s2  <= r_right_s1;
      r_fire_s1   <= fire;
      r_fire_s2   <= r_fire_s1;
      r_fire_prev <= r_sync_vld[1] ? r_fire_s2 : 1'b1;
      r_sync_vld  <= {r_sync_vld[0], 1'b1};
    end
  end

  assign w_fire_rise = r_fire_s2 & ~r_fire_prev;

  always_comb begin
    w_cnt_nxt = (r_cnt == c_cnt_last) ? '0 : r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_frame_tick <= (w_cnt_nxt == c_cnt_last);
    end
  end

  // Extra bit keeps the clamp compares free of wrap-around.
  always_comb begin
    w_x_ext = {1'b0, r_player_x};
    w_x_nxt = r_player_x;
    if (r_frame_tick && r_left_s2 && !r_right_s2) begin
      w_x_nxt = (w_x_ext < c_left_lim) ? c_x_min : X_W'(w_x_ext - c_step);
    end else if (r_frame_tick && r_right_s2 && !r_left_s2) begin
      w_x_nxt = ((w_x_ext + c_step) > c_right_lim) ? c_x_max : X_W'(w_x_ext + c_step);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cd    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cd    <= w_cd_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cd_nxt    = r_cd;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fire_rise) begin
          w_state_nxt = ST_REQ;
          w_capture   = 1'b1;
        end
      end
      ST_REQ: begin
        if (shot_ack) begin
          w_state_nxt = ST_COOL;
          w_cd_nxt    = c_cd_load;
        end
      end
      ST_COOL: begin
        if (r_cd == '0) begin
          w_state_nxt = ST_IDLE;
        end else if (r_frame_tick) begin
          w_cd_nxt = r_cd - CD_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture uses the pre-update position when a motion tick coincides.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_player_x <= c_x_reset;
      r_shot_req <= 1'b0;
      r_shot_x   <= '0;
    end else begin
      r_player_x <= w_x_nxt;
      r_shot_req <= (w_state_nxt == ST_REQ);
      if (w_capture) begin
        r_shot_x <= r_player_x + c_offset;
      end
    end
  end

  assign frame_tick = r_frame_tick;
  assign player_x   = r_player_x;
  assign shot_req   = r_shot_req;
  assign shot_x     = r_shot_x;
  assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_player_ctrl.sv
`default_nettype none
// =============================================================================
// Module  : tb_player_ctrl
// Brief   : Self-checking bench for player_ctrl (STEP=4 and STEP=5 instances).
// Rev     : 1.0  initial release
// =============================================================================
module tb_player_ctrl;

  localparam int TICK_DIV    = 4;
  localparam int X_W         = 10;
  localparam int X_MIN       = 0;
  localparam int X_MAX       = 608;
  localparam int X_RESET     = 304;
  localparam int SHOT_OFFSET = 14;
  localparam int COOLDOWN    = 15;
  localparam int NDUT        = 2;

  logic clk = 1'b0;
  logic rst, left, right, fire, shot_ack;
  logic           tick_o [NDUT];
  logic [X_W-1:0] x_o    [NDUT];
  logic           req_o  [NDUT];
  logic [X_W-1:0] sx_o   [NDUT];
  logic           busy_o [NDUT];

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  int m_e;
  bit q_l[$], q_r[$], q_f[$];
  bit m_tick;
  int m_x    [NDUT];
  int m_sx   [NDUT];
  bit m_pend [NDUT];
  int m_cool [NDUT];  // -1 when not cooling

  always #5 clk = ~clk;

  player_ctrl #(
    .TICK_DIV(TICK_DIV), .X_W(X_W), .X_MIN(X_MIN), .X_MAX(X_MAX), .X_RESET(X_RESET),
    .STEP(4), .SHOT_OFFSET(SHOT_OFFSET), .COOLDOWN(COOLDOWN)
  ) dut (
    .clk(clk), .rst(rst), .left(left), .right(right), .fire(fire), .shot_ack(shot_ack),
    .frame_tick(tick_o[0]), .player_x(x_o[0]), .shot_req(req_o[0]), .shot_x(sx_o[0]),
    .busy(busy_o[0])
  );

  player_ctrl #(
    .TICK_DIV(TICK_DIV), .X_W(X_W), .X_MIN(X_MIN), .X_MAX(X_MAX), .X_RESET(X_RESET),
    .STEP(5), .SHOT_OFFSET(SHOT_OFFSET), .COOLDOWN(COOLDOWN)
  ) dut5 (
    .clk(clk), .rst(rst), .left(left), .right(right), .fire(fire), .shot_ack(shot_ack),
    .frame_tick(tick_o[1]), .player_x(x_o[1]), .shot_req(req_o[1]), .shot_x(sx_o[1]),
    .busy(busy_o[1])
  );

  function automatic int step_of(int i);
    return (i == 0) ? 4 : 5;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    bit l2, r2, rise, tick_pre;
    int old_x;
    if (rst) begin
      m_e = 0;
      q_l.delete(); q_r.delete(); q_f.delete();
      m_tick = 1'b0;
      for (int i = 0; i < NDUT; i++) begin
        m_x[i] = X_RESET; m_sx[i] = 0; m_pend[i] = 1'b0; m_cool[i] = -1;
      end
      return;
    end
    m_e++;
    tick_pre = m_tick;
    l2   = (m_e >= 3) ? q_l[$-1] : 1'b0;
    r2   = (m_e >= 3) ? q_r[$-1] : 1'b0;
    rise = (m_e >= 4) ? (q_f[$-1] && !q_f[$-2]) : 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      old_x = m_x[i];
      if (tick_pre && l2 && !r2)
        m_x[i] = (old_x - step_of(i) < X_MIN) ? X_MIN : old_x - step_of(i);
      else if (tick_pre && r2 && !l2)
        m_x[i] = (old_x + step_of(i) > X_MAX) ? X_MAX : old_x + step_of(i);
      if (!m_pend[i] && m_cool[i] < 0) begin
        if (rise) begin
          m_pend[i] = 1'b1;
          m_sx[i]   = (old_x + SHOT_OFFSET) % (1 << X_W);
        end
      end else if (m_pend[i]) begin
        if (shot_ack) begin
          m_pend[i] = 1'b0;
          m_cool[i] = COOLDOWN;
        end
      end else begin
        if (m_cool[i] == 0) m_cool[i] = -1;
        else if (tick_pre) m_cool[i] = m_cool[i] - 1;
      end
    end
    q_l.push_back(left); q_r.push_back(right); q_f.push_back(fire);
    while (q_f.size() > 4) begin
      void'(q_l.pop_front()); void'(q_r.pop_front()); void'(q_f.pop_front());
    end
    m_tick = ((m_e % TICK_DIV) == TICK_DIV - 1);
  endtask

  task automatic check_all();
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("frame_tick[%0d]", i), 32'(tick_o[i]), 32'(m_tick));
      chk($sformatf("player_x[%0d]", i),   32'(x_o[i]),    m_x[i]);
      chk($sformatf("shot_req[%0d]", i),   32'(req_o[i]),  32'(m_pend[i]));
      chk($sformatf("shot_x[%0d]", i),     32'(sx_o[i]),   m_sx[i]);
      chk($sformatf("busy[%0d]", i),       32'(busy_o[i]), 32'(m_pend[i] || m_cool[i] >= 0));
    end
  endtask

  task automatic tick1();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic wait_idle(int budget);
    int k = 0;
    while (busy_o[0] !== 1'b0 && k < budget) begin
      tick1();
      k++;
    end
    chk("wait_idle_timeout", 32'(busy_o[0]), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick1();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; left = 1'b0; right = 1'b0; fire = 1'b0; shot_ack = 1'b0;
    repeat (3) tick1();
    chk("rst_player_x", 32'(x_o[0]), 304);
    chk("rst_shot_req", 32'(req_o[0]), 0);
    chk("rst_busy", 32'(busy_o[0]), 0);
    chk("rst_shot_x", 32'(sx_o[0]), 0);
    rst = 1'b0;

    // frame_tick first at cycle 3 after release, then every 4th
    for (int k = 1; k <= 8; k++) begin
      tick1();
      chk("tick_pattern", 32'(tick_o[0]), 32'((k % 4) == 3));
    end

    // right saturation
    right = 1'b1;
    repeat (100 * TICK_DIV) tick1();
    chk("sat_right_s4", 32'(x_o[0]), 608);
    chk("sat_right_s5", 32'(x_o[1]), 608);

    // conflicting steer at the right edge
    left = 1'b1;
    repeat (10 * TICK_DIV) tick1();
    chk("both_hold_edge", 32'(x_o[0]), 608);

    // left saturation from reset position, STEP=5 passes through 4 then 0
    right = 1'b0;
    do_reset();
    repeat (100 * TICK_DIV) tick1();
    chk("sat_left_s4", 32'(x_o[0]), 0);
    chk("sat_left_s5", 32'(x_o[1]), 0);

    // conflicting steer mid-field
    right = 1'b1;
    do_reset();
    repeat (10 * TICK_DIV) tick1();
    chk("both_hold_mid", 32'(x_o[0]), 304);
    left = 1'b0; right = 1'b0;

    // fire / handshake / cooldown
    do_reset();
    repeat (6) tick1();
    fire = 1'b1;
    tick1();
    fire = 1'b0;
    chk("shot_lat_1", 32'(req_o[0]), 0);
    tick1();
    chk("shot_lat_2", 32'(req_o[0]), 0);
    tick1();
    chk("shot_lat_3", 32'(req_o[0]), 1);
    chk("shot_x_318", 32'(sx_o[0]), 318);
    for (int k = 0; k < 4; k++) begin
      tick1();
      chk("req_held", 32'(req_o[0]), 1);
    end
    shot_ack = 1'b1;
    tick1();
    shot_ack = 1'b0;
    chk("ack_drops_req", 32'(req_o[0]), 0);
    chk("cooldown_busy", 32'(busy_o[0]), 1);
    for (int p = 0; p < 7; p++) begin
      fire = 1'b1;
      tick1();
      fire = 1'b0;
      repeat (7) tick1();
      chk("cd_fire_ignored", 32'(req_o[0]), 0);
    end
    wait_idle(40);
    repeat (2) tick1();
    fire = 1'b1;
    tick1();
    fire = 1'b0;
    repeat (2) tick1();
    chk("post_cd_accept", 32'(req_o[0]), 1);

    // reset during REQ with fire held through release
    shot_ack = 1'b1;
    tick1();
    shot_ack = 1'b0;
    wait_idle(100);
    repeat (2) tick1();
    fire = 1'b1;
    repeat (3) tick1();
    chk("req_before_rst", 32'(req_o[0]), 1);
    do_reset();
    chk("rst_mid_req", 32'(req_o[0]), 0);
    chk("rst_mid_x", 32'(x_o[0]), 304);
    repeat (20) tick1();
    chk("held_no_shot", 32'(req_o[0]), 0);
    fire = 1'b0;
    repeat (3) tick1();
    fire = 1'b1;
    repeat (3) tick1();
    chk("refire_after_release", 32'(req_o[0]), 1);
    fire = 1'b0;

    // randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      rst      = ($urandom_range(0, 299) == 0);
      shot_ack = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) left  = ~left;
      if ($urandom_range(0, 7) == 0) right = ~right;
      if ($urandom_range(0, 5) == 0) fire  = ~fire;
      tick1();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/player_ctrl.md
# player_ctrl

Player-ship motion and fire controller for the shoot-em-up. It consumes the `left`/`right` steering decisions and the joystick trigger bit from the joystick controller stage. It integrates them at a fixed frame rate into a clamped horizontal ship position, and issues handshaked shot requests to the projectile manager with a cooldown between shots. It also exports the frame tick so downstream game logic updates in lockstep.

## Interface
- `TICK_DIV`, 1666667: clk cycles per frame tick (60 Hz at 100 MHz).
- `X_W`, 10: width of position buses.
- `X_MIN`, 0: leftmost legal `player_x`.
- `X_MAX`, 608: rightmost legal `player_x` (640 minus 32-px sprite).
- `X_RESET`, 304: `player_x` after reset.
- `STEP`, 4: pixels moved per tick while steering.
- `SHOT_OFFSET`, 14: added to `player_x` to form `shot_x` (sprite centre).
- `COOLDOWN`, 15: ticks after an accepted shot before a new fire edge is honoured.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `left` in 1: steer left request (level).
- `right` in 1: steer right request (level).
- `fire` in 1: joystick trigger button (level, unsynchronised).
- `shot_ack` in 1: projectile manager accepts the pending shot.
- `frame_tick` out 1: one-cycle pulse per frame.
- `player_x` out X_W: ship left-edge x coordinate.
- `shot_req` out 1: shot pending; held until acknowledged.
- `shot_x` out X_W: spawn x of the pending or most recent shot.
- `busy` out 1: high in REQ or COOLDOWN.

## Operation
- **Input sync.** `left`, `right` and `fire` each pass through two flops (s1→s2). All logic uses the s2 values. Sync flops reset to 0.
- **Tick divider.** Counter runs 0..TICK_DIV-1. `frame_tick`=1 in the cycle where counter==TICK_DIV-1. The counter then wraps to 0. Counter resets to 0.
- **Motion.** Evaluated only on cycles with `frame_tick`=1:
  - Left only: if `player_x` < X_MIN+STEP, set X_MIN; else subtract STEP.
  - Right only: if `player_x` > X_MAX-STEP, set X_MAX; else add STEP.
  - Both or neither: hold.
  - Compare in X_W+1 bits. No wrap-around under any parameter set where X_MIN ≤ X_RESET ≤ X_MAX < 2^X_W.
- **Fire edge.** `fire_rise` = s2 & ~fire_prev. `fire_prev` resets to 1, so a button held through reset release does not shoot. Holding fire never auto-repeats.
- **Fire FSM** (states IDLE, REQ, COOLDOWN; reset state IDLE):
  - IDLE: on `fire_rise`, go to REQ and latch `shot_x` = `player_x` + SHOT_OFFSET. Use the pre-update `player_x` if a motion tick occurs in the same cycle. Truncate the sum to X_W bits.
  - REQ: `shot_req`=1. On `shot_ack`=1, go to COOLDOWN and load cd_cnt=COOLDOWN. `shot_ack` outside REQ is ignored.
  - COOLDOWN: decrement cd_cnt on each `frame_tick`. When cd_cnt is 0, go to IDLE on the next cycle. COOLDOWN=0 therefore returns to IDLE after one cycle.
  - Fire edges in REQ or COOLDOWN are discarded, not queued.
- `busy` = (state != IDLE).

## Timing
- **Reset values:** `player_x`=X_RESET, `shot_x`=0, `shot_req`=0, `busy`=0, `frame_tick`=0. Reset mid-REQ or mid-COOLDOWN aborts to IDLE, and `shot_req` is low in the cycle after `rst` is sampled.
- **Input latency:** an input change at edge n is visible to logic at edge n+2.
- **Motion latency:** `player_x` updates on the clock edge that samples `frame_tick`=1. The new value is visible the following cycle, one update per tick.
- **Shot latency:** `fire` rising at edge n gives `shot_req`=1 from edge n+3.
- **Handshake:** `shot_ack` sampled high while `shot_req`=1 drops `shot_req` on the next edge. `shot_ack` is permitted in the first REQ cycle. `shot_x` is stable throughout REQ.
- All outputs are registered except `busy`, which is decoded from the state register.

## Test plan
Simulate with TICK_DIV=4.
- **Reset and tick:** release `rst` → `player_x`=304, `shot_req`=0, `busy`=0. `frame_tick` pulses every 4th cycle, first at cycle 3 after release.
- **Right saturation:** hold `right` for 100 ticks → `player_x` rises 4 per tick, reaches 608 after 76 ticks, then stays at 608. Repeat with `left` → falls to 0 and holds.
- **Non-multiple clamp:** STEP=5, hold `left` → 304, 299, … 4, then 0; never wraps to a large value.
- **Conflicting steer:** `left`=`right`=1 for 10 ticks → `player_x` unchanged.
- **Fire/handshake/cooldown:** pulse `fire` with `player_x`=304, then assert `shot_ack` 5 cycles after `shot_req` rises:
  - `shot_x`=318 and `shot_req` held high for those 5 cycles.
  - A fire pulse during the following 15 ticks yields no request.
  - After cooldown expires, the next pulse is accepted.
- **Reset mid-operation and held button:** assert `rst` during REQ → `shot_req`=0 next cycle and `player_x`=304. Keep `fire` high through reset release → no shot until `fire` goes low and high again.
